// File: rtl/reg_file.sv
// Register file: 2**ADDR_W x DATA_W entries, entry 0 hardwired to zero, two registered read ports.
// Define RF_BYPASS_EN to forward a same-edge write to the read ports.
module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic              stall,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic              we,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic              rd_valid
);

  localparam int unsigned NUM_ENTRIES = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [NUM_ENTRIES];
  logic [DATA_W-1:0] mem_d [NUM_ENTRIES];

  logic [DATA_W-1:0] rs1_data_q, rs1_data_d;
  logic [DATA_W-1:0] rs2_data_q, rs2_data_d;
  logic              rd_valid_q, rd_valid_d;

  logic              wr_hit;
  logic [DATA_W-1:0] rs1_rdata;
  logic [DATA_W-1:0] rs2_rdata;

  assign wr_hit = we && (rd != '0);

  // Entry 0 is never written, so it keeps its reset value of zero.
  always_comb begin
    mem_d = mem_q;
    if (wr_hit) begin
      mem_d[rd] = wd;
    end
  end

  always_comb begin
    rs1_rdata = '0;
    rs2_rdata = '0;
    if (rs1 != '0) begin
      rs1_rdata = mem_q[rs1];
    end
    if (rs2 != '0) begin
      rs2_rdata = mem_q[rs2];
    end
`ifdef RF_BYPASS_EN
    if (wr_hit && (rd == rs1)) begin
      rs1_rdata = wd;
    end
    if (wr_hit && (rd == rs2)) begin
      rs2_rdata = wd;
    end
`endif
  end

  // Stall freezes all read outputs; an idle cycle drops valid but keeps the data.
  always_comb begin
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    rd_valid_d = rd_valid_q;
    if (!stall) begin
      rd_valid_d = rd_en;
      if (rd_en) begin
        rs1_data_d = rs1_rdata;
        rs2_data_d = rs2_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        mem_q[i] <= '0;
      end
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        mem_q[i] <= mem_d[i];
      end
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rs1_data = rs1_data_q;
  assign rs2_data = rs2_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter DATA_W, default 32, register data width.
REQ-002 Parameter ADDR_W, default 5, register index width (2**ADDR_W entries).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 rd_en  input  1  read request valid; rs1/rs2 qualified by it.
REQ-006 stall  input  1  downstream stall; freezes read outputs.
REQ-007 rs1  input  ADDR_W  source register 1 index, from the decode field-extract stage.
REQ-008 rs2  input  ADDR_W  source register 2 index, from the decode field-extract stage.
REQ-009 we  input  1  write enable from writeback.
REQ-010 rd  input  ADDR_W  destination register index.
REQ-011 wd  input  DATA_W  write data.
REQ-012 rs1_data  output  DATA_W  registered read data for rs1.
REQ-013 rs2_data  output  DATA_W  registered read data for rs2.
REQ-014 rd_valid  output  1  rs1_data/rs2_data valid.

Function
REQ-015 Storage SHALL be 2**ADDR_W entries of DATA_W bits; entry 0 SHALL always read as zero.
REQ-016 On a rising edge with we=1 and rd!=0, entry rd SHALL take wd; writes with rd=0 SHALL be discarded.
REQ-017 Writes SHALL proceed regardless of rd_en and stall.
REQ-018 Read latency SHALL be one cycle: on a rising edge with rd_en=1, stall=0, rs1_data/rs2_data SHALL capture entries rs1/rs2 and rd_valid SHALL become 1.
REQ-019 On a rising edge with rd_en=0, stall=0, rd_valid SHALL become 0 and rs1_data/rs2_data SHALL hold.
REQ-020 On a rising edge with stall=1, rs1_data, rs2_data and rd_valid SHALL hold unchanged, independent of rd_en and of any concurrent write.
REQ-021 A read of index 0 SHALL capture zero even if the same edge carries we=1, rd=0.
REQ-022 A same-edge write and read to the same nonzero index SHALL follow REQ-030/REQ-031.
REQ-023 rs1=rs2 SHALL return identical data on both ports.
REQ-024 Back-to-back reads (rd_en=1 every cycle, stall=0) SHALL give one valid result per cycle with no bubbles.

Reset
REQ-025 rst_n low SHALL immediately, without a clock edge, clear all entries, rs1_data, rs2_data to 0 and rd_valid to 0.
REQ-026 While rst_n is low, writes and reads SHALL be ignored.
REQ-027 Reset asserted mid-operation (including during stall) SHALL discard held outputs and pending write.
REQ-028 The first rising edge with rst_n high SHALL perform normal read/write per REQ-016..REQ-024.

Configuration
REQ-029 Macro RF_BYPASS_EN SHALL select same-edge write-to-read forwarding.
REQ-030 With RF_BYPASS_EN defined: for a read capturing on the same edge as a write with rd==rs1 (or rs2), rd!=0, the captured rs1_data (rs2_data) SHALL equal wd.
REQ-031 Without RF_BYPASS_EN: that read SHALL capture the pre-write entry value; the new value SHALL be visible to reads from the next edge.

Verification
REQ-032 Reset: drive rst_n=0 mid-run with rd_valid=1 -> rs1_data=rs2_data=0, rd_valid=0 without a clock edge; read every index after release -> all 0.
REQ-033 Write/read: we=1, rd=5, wd=0xDEADBEEF; next cycle rd_en=1, rs1=5, rs2=0 -> one cycle later rs1_data=0xDEADBEEF, rs2_data=0, rd_valid=1.
REQ-034 x0: we=1, rd=0, wd=0xFFFFFFFF; then read rs1=0 -> rs1_data=0.
REQ-035 Bypass: entry 7=0x11111111; same edge we=1, rd=7, wd=0x22222222, rd_en=1, rs1=7 -> rs1_data=0x22222222 with RF_BYPASS_EN, 0x11111111 without.
REQ-036 Stall: valid output 0x00000ABC on rs1_data; assert stall 3 cycles while writing rd=rs1 with wd=0x123 and toggling rd_en -> rs1_data=0x00000ABC, rd_valid=1 throughout; drop stall with rd_en=1 -> next cycle rs1_data=0x00000123.
REQ-037 Streaming: rd_en=1, stall=0 for 32 cycles, rs1=i, rs2=31-i after writing entry i with value i*0x01010101 -> rd_valid=1 every cycle, correct data each cycle, entry 0 reads 0.
